// File: rtl/parking_request_issuer_if.sv
// Bundle between the gate keypad/lot controller and parking_request_issuer.
// master: the issuer itself (consumes keys and lot_busy, drives requests and status).
// slave:  the environment that feeds keys and receives requests.
interface parking_request_issuer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                          key_valid;
    logic [3:0]                    key_code;
    logic                          lot_busy;
    logic [15:0]                   license_plate;
    logic                          in_mode;
    logic                          out_mode;
    logic [15:0]                   entry_buf;
    logic [2:0]                    entry_count;
    logic [$clog2(FIFO_DEPTH):0]   queue_count;
    logic                          queue_full;
    logic                          err_pulse;

    modport master (
        input  key_valid, key_code, lot_busy,
        output license_plate, in_mode, out_mode,
        output entry_buf, entry_count, queue_count, queue_full, err_pulse
    );

    modport slave (
        output key_valid, key_code, lot_busy,
        input  license_plate, in_mode, out_mode,
        input  entry_buf, entry_count, queue_count, queue_full, err_pulse
    );
endinterface

// File: rtl/parking_request_issuer.sv
// Gate-side request issuer: assembles 4-digit BCD plates from keypad strobes, queues
// in/out requests and issues them as single-cycle pulses paced by lot_busy and a gap.
// Optional macro PARKING_REQ_DEDUP_EN: reject an enter whose {mode, plate} is already queued.
module parking_request_issuer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input logic                       clock,
    input logic                       reset_n,
    parking_request_issuer_if.master  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    logic [15:0]   entry_buf_q, entry_buf_d;
    logic [2:0]    entry_count_q, entry_count_d;
    logic          err_q, err_d;
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   plate_q, plate_d;
    logic          in_q, in_d, out_q, out_d;

    logic        is_digit, is_clear, is_enter, enter_mode;
    logic        full, dup, enter_ok, push, pop;
    logic [16:0] head;

    assign is_digit   = (bus.key_code <= 4'd9);
    assign is_clear   = (bus.key_code == 4'hC);
    assign is_enter   = (bus.key_code == 4'hE) || (bus.key_code == 4'hF);
    assign enter_mode = (bus.key_code == 4'hE);
    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];

    // Duplicate search over occupied slots; the head stays occupied until ISSUE exits.
    always_comb begin
        dup = 1'b0;
`ifdef PARKING_REQ_DEDUP_EN
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (mem_q[AW'(rd_ptr_q + AW'(i))] == {enter_mode, entry_buf_q})) begin
                dup = 1'b1;
            end
        end
`endif
    end

    // Plate 0000 means "empty slot" on the lot side, so it is never enqueued.
    assign enter_ok = (entry_count_q == 3'd4) && (entry_buf_q != 16'h0000) && !full && !dup;
    assign push     = bus.key_valid && is_enter && enter_ok;
    assign pop      = (state_q == StIssue);
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Keypad entry next-state and error flag.
    always_comb begin
        entry_buf_d   = entry_buf_q;
        entry_count_d = entry_count_q;
        err_d         = 1'b0;
        if (bus.key_valid) begin
            if (is_digit) begin
                if (entry_count_q < 3'd4) begin
                    entry_buf_d   = {entry_buf_q[11:0], bus.key_code};
                    entry_count_d = entry_count_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_clear) begin
                entry_buf_d   = 16'h0000;
                entry_count_d = 3'd0;
            end else if (is_enter) begin
                if (enter_ok) begin
                    entry_buf_d   = 16'h0000;
                    entry_count_d = 3'd0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Entry registers and FIFO bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_buf_q   <= 16'h0000;
            entry_count_q <= 3'd0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            entry_buf_q   <= entry_buf_d;
            entry_count_q <= entry_count_d;
            err_q         <= err_d;
            count_q       <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // FIFO storage; contents are don't-care outside the occupied range.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {enter_mode, entry_buf_q};
    end

    // Issue FSM next-state and registered request outputs.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        plate_d = plate_q;
        in_d    = in_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && !bus.lot_busy) begin
                    state_d = StIssue;
                    plate_d = head[15:0];
                    in_d    = head[16];
                    out_d   = !head[16];
                end
            end
            StIssue: begin
                state_d = StGap;
                gap_d   = '0;
                plate_d = 16'h0000;
                in_d    = 1'b0;
                out_d   = 1'b0;
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = StIdle;
                else                              gap_d   = gap_q + GW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            gap_q   <= '0;
            plate_q <= 16'h0000;
            in_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            plate_q <= plate_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    assign bus.license_plate = plate_q;
    assign bus.in_mode       = in_q;
    assign bus.out_mode      = out_q;
    assign bus.entry_buf     = entry_buf_q;
    assign bus.entry_count   = entry_count_q;
    assign bus.queue_count   = count_q;
    assign bus.queue_full    = full;
    assign bus.err_pulse     = err_q;
endmodule

// File: doc/parking_request_issuer.md
Name: parking_request_issuer

Overview:
- Gate-side front end that drives the parking lot controller's request inputs.
- Collects keypad entries one BCD digit at a time and assembles a 4-digit plate.
- Queues completed in/out requests in a small FIFO.
- Issues each request as a single-cycle license_plate + in_mode/out_mode pulse, paced by the lot's busy flag and a minimum inter-request gap.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, ≥2)
- GAP_CYCLES, 8, idle cycles forced after each issued request (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe qualifying key_code
- key_code  in  4  0-9 digit; 4'hC clear; 4'hE enter-in; 4'hF enter-out; others invalid
- lot_busy  in  1  lot has pending work (todo_exists); blocks issue
- license_plate  out  16  BCD plate {d3,d2,d1,d0}, valid only in issue cycle, else 0
- in_mode  out  1  one-cycle park request
- out_mode  out  1  one-cycle retrieve request
- entry_buf  out  16  digits entered so far, right-justified BCD
- entry_count  out  3  digits entered, 0..4
- queue_count  out  $clog2(FIFO_DEPTH)+1  queued requests
- queue_full  out  1  queue_count == FIFO_DEPTH
- err_pulse  out  1  one-cycle flag: last key rejected

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FIFO flushed; entry cleared; issue FSM to IDLE. Applies mid-issue or mid-gap; an in-flight pulse drops immediately.
- Entry logic: acts only when key_valid=1; all results register on that edge.
  - Digit with entry_count<4: entry_buf <= {entry_buf[11:0], key_code}; entry_count+1.
  - Digit with entry_count==4: ignored; err_pulse.
  - Clear (4'hC): entry_buf=0, entry_count=0; no error.
  - Enter (E/F) is accepted when entry_count==4, entry_buf!=16'h0000 and queue not full. On accept: push {mode, entry_buf} with mode 1=in, 0=out; entry cleared.
  - Enter failing any of those conditions: err_pulse; entry kept.
  - Plate 0000 is rejected because the lot uses 0000 as "empty slot".
  - Invalid codes (A, B, D): err_pulse; no state change.
- Queue-full check uses the registered count. A pop in the same cycle does not free space for that cycle's push.
- Simultaneous push and pop: both occur; queue_count unchanged.
- Issue FSM: IDLE -> ISSUE -> GAP -> IDLE.
  - IDLE: when queue_count>0 and lot_busy=0 at the edge, go to ISSUE. The head is loaded into the output registers on that same edge.
  - ISSUE (exactly 1 cycle): license_plate=head plate; exactly one of in_mode/out_mode is 1. Head pops at the exit edge; outputs return to 0.
  - GAP: counter runs GAP_CYCLES cycles with outputs 0, then IDLE. lot_busy is ignored outside IDLE.
- Latency: enter sampled at edge E0 (push). Earliest issue is the pulse between E1 and E2, provided lot_busy=0 at E1.
- Back-to-back issue spacing is at least GAP_CYCLES+2 edges.
- in_mode and out_mode are never both 1.
- err_pulse is registered and lasts 1 cycle per rejected key.

Optional Feature:
- Macro: PARKING_REQ_DEDUP_EN.
- Defined: an enter whose {mode, plate} matches any valid FIFO entry (including the head while in ISSUE) is rejected with err_pulse; entry kept.
- Undefined: duplicates are queued and issued normally.

Test Plan:
- Keys 9,4,2,3,E with lot_busy=0 -> queue_count 1 after E. One-cycle license_plate=16'h9423, in_mode=1 on the cycle after the push; queue_count 0 after.
- Keys 8,7,5,4,F while lot_busy=1 for 20 cycles -> no pulse during busy. out_mode=1 with plate 16'h8754 starting the cycle after lot_busy falls.
- Two full requests entered back-to-back (1429 in, 6425 out) -> pulses separated by exactly GAP_CYCLES+2=10 edges, in order.
- Entry errors:
  - Enter after 3 digits -> err_pulse, entry_count stays 3.
  - Fifth digit -> err_pulse.
  - 0,0,0,0,E -> err_pulse, nothing queued.
  - C -> entry_count 0.
- Fill FIFO_DEPTH=4 with lot_busy=1 -> queue_full=1; fifth enter -> err_pulse, queue_count 4. reset_n low mid-GAP -> all outputs 0 asynchronously, queue_count 0.
- With PARKING_REQ_DEDUP_EN, 5424 in entered twice while lot_busy=1 -> second enter gives err_pulse, queue_count 1. Without the macro -> queue_count 2.
